acc_ctrl: RTL and testbench

Multi-cycle control unit for the 8-bit accumulator datapath. Fetches 8-bit instructions from a 32×8 synchronous RAM and decodes them. Sequences the datapath controls (`Asel`, `Aload`, `Sub`) and the RAM address and write strobe, and branches on the datapath status flags `Aeq0` and `Apos`. Sits between the program/data RAM and the accumulator datapath as the processor's only state machine.

---
 rtl/acc_ctrl.sv | 166 ++++++++++++++++
 tb/tb_acc_ctrl.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_ctrl.sv
// acc_ctrl: multi-cycle fetch/decode/execute controller for the 8-bit accumulator datapath.
// Optional feature macro: CTRL_SINGLE_STEP_EN (FETCH waits for Step before each instruction).
module acc_ctrl #(
    parameter logic [4:0] RESET_PC = 5'd0
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] RamQ,
    input  logic       Aeq0,
    input  logic       Apos,
    input  logic       Enter,
    input  logic       Step,
    output logic [4:0] RamAddr,
    output logic       RamWe,
    output logic [1:0] Asel,
    output logic       Aload,
    output logic       Sub,
    output logic       Halt,
    output logic [4:0] PcOut,
    output logic [2:0] StateOut
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEMRD  = 3'd3,
        INREL  = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_INPUT = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [4:0] pc_r;
    logic [7:0] ir_r;
    logic [2:0] op_s;
    logic [4:0] addr_s;
    logic       step_go_s;
    logic       branch_s;

    assign op_s   = ir_r[7:5];
    assign addr_s = ir_r[4:0];

`ifdef CTRL_SINGLE_STEP_EN
    assign step_go_s = Step;
`else
    // Step has no effect in this build; FETCH always advances.
    assign step_go_s = Step | 1'b1;
`endif

    // Branch condition for JZ/JPOS, sampled from the datapath flags during EXEC.
    always_comb begin
        branch_s = 1'b0;
        if (op_s == OP_JZ) begin
            branch_s = Aeq0;
        end else if (op_s == OP_JPOS) begin
            branch_s = Apos;
        end else begin
            branch_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Program counter and instruction register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pc_r <= RESET_PC;
            ir_r <= 8'd0;
        end else if (state_r == DECODE) begin
            ir_r <= RamQ;
            pc_r <= pc_r + 5'd1;
        end else if ((state_r == EXEC) && branch_s) begin
            pc_r <= addr_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = FETCH;
        case (state_r)
            FETCH:  state_nxt_s = step_go_s ? DECODE : FETCH;
            DECODE: state_nxt_s = EXEC;
            EXEC: begin
                case (op_s)
                    OP_LOAD, OP_ADD, OP_SUB:   state_nxt_s = MEMRD;
                    OP_STORE, OP_JZ, OP_JPOS:  state_nxt_s = FETCH;
                    OP_INPUT:                  state_nxt_s = Enter ? INREL : EXEC;
                    OP_HALT:                   state_nxt_s = HALT;
                    default:                   state_nxt_s = FETCH;
                endcase
            end
            MEMRD:  state_nxt_s = FETCH;
            INREL:  state_nxt_s = Enter ? INREL : FETCH;
            HALT:   state_nxt_s = HALT;
            default: state_nxt_s = FETCH;
        endcase
    end

    // Control outputs, decoded from state, IR and Enter.
    always_comb begin
        RamAddr = pc_r;
        RamWe   = 1'b0;
        Asel    = 2'b00;
        Aload   = 1'b0;
        Sub     = 1'b0;
        Halt    = 1'b0;
        case (state_r)
            FETCH, DECODE: RamAddr = pc_r;
            EXEC: begin
                RamAddr = addr_s;
                case (op_s)
                    OP_STORE: RamWe = 1'b1;
                    OP_INPUT: begin
                        if (Enter) begin
                            Asel  = 2'b01;
                            Aload = 1'b1;
                        end else begin
                            Asel  = 2'b00;
                            Aload = 1'b0;
                        end
                    end
                    default: RamWe = 1'b0;
                endcase
            end
            MEMRD: begin
                RamAddr = addr_s;
                case (op_s)
                    OP_LOAD: begin
                        Asel  = 2'b10;
                        Aload = 1'b1;
                    end
                    OP_ADD: Aload = 1'b1;
                    OP_SUB: begin
                        Sub   = 1'b1;
                        Aload = 1'b1;
                    end
                    default: Aload = 1'b0;
                endcase
            end
            INREL:  RamAddr = addr_s;
            HALT:   Halt = 1'b1;
            default: RamAddr = pc_r;
        endcase
    end

    assign PcOut    = pc_r;
    assign StateOut = state_r;

endmodule

// File: tb/tb_acc_ctrl.sv
// Self-checking bench for acc_ctrl: behavioural RAM + accumulator datapath around the
// controller, with scoreboard queues of expected accumulator loads and RAM writes.
module tb_acc_ctrl;

    typedef struct packed {
        logic [1:0] asel;
        logic       sub;
        logic [7:0] val;
    } ld_t;

    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] ram_q = 8'd0;
    logic       Aeq0;
    logic       Apos;
    logic       Enter = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
    logic       Step = 1'b1;
`else
    logic       Step = 1'b0;
`endif
    logic [4:0] RamAddr;
    logic       RamWe;
    logic [1:0] Asel;
    logic       Aload;
    logic       Sub;
    logic       Halt;
    logic [4:0] PcOut;
    logic [2:0] StateOut;

    logic [7:0] mem [32];
    logic [7:0] acc;
    logic [7:0] in_data = 8'd0;

    int  chk = 0;
    int  err = 0;
    int  aload_cnt = 0;
    ld_t ld_q [$];
    wr_t wr_q [$];
    logic       ld_pend = 1'b0;
    logic [7:0] ld_exp = 8'd0;

    localparam logic [7:0] I_HALT = 8'hE0;

    acc_ctrl #(.RESET_PC(5'd0)) dut (
        .Clock(Clock), .Reset(Reset), .RamQ(ram_q), .Aeq0(Aeq0), .Apos(Apos),
        .Enter(Enter), .Step(Step), .RamAddr(RamAddr), .RamWe(RamWe), .Asel(Asel),
        .Aload(Aload), .Sub(Sub), .Halt(Halt), .PcOut(PcOut), .StateOut(StateOut)
    );

    always #5 Clock = ~Clock;

    assign Aeq0 = (acc == 8'd0);
    assign Apos = ~acc[7];

    always @(posedge Clock) begin
        if (Reset && RamWe) mem[RamAddr] = acc;
        ram_q <= mem[RamAddr];
    end

    always @(posedge Clock or negedge Reset) begin
        if (!Reset) acc <= 8'd0;
        else if (Aload) begin
            case (Asel)
                2'b00:   acc <= Sub ? (acc - ram_q) : (acc + ram_q);
                2'b01:   acc <= in_data;
                default: acc <= ram_q;
            endcase
        end
    end

    // Scoreboard monitor: pops expected loads/writes when the DUT strobes them.
    always @(negedge Clock) begin
        ld_t e;
        wr_t w;
        if (!Reset) begin
            ld_pend = 1'b0;
        end else begin
            if (ld_pend) begin
                chk++;
                if (acc !== ld_exp) begin
                    err++;
                    $display("FAIL acc_after_aload: got %h expected %h", acc, ld_exp);
                end
                ld_pend = 1'b0;
            end
            if (Aload === 1'b1) begin
                aload_cnt++;
                chk++;
                if (ld_q.size() == 0) begin
                    err++;
                    $display("FAIL unexpected_aload: asel %b sub %b, expected none", Asel, Sub);
                end else begin
                    e = ld_q.pop_front();
                    if (Asel !== e.asel || Sub !== e.sub) begin
                        err++;
                        $display("FAIL aload_ctrl: asel %b sub %b expected asel %b sub %b",
                                 Asel, Sub, e.asel, e.sub);
                    end
                    ld_exp  = e.val;
                    ld_pend = 1'b1;
                end
            end
            if (RamWe === 1'b1) begin
                chk++;
                if (wr_q.size() == 0) begin
                    err++;
                    $display("FAIL unexpected_write: addr %0d data %h, expected none", RamAddr, acc);
                end else begin
                    w = wr_q.pop_front();
                    if (RamAddr !== w.addr || acc !== w.data) begin
                        err++;
                        $display("FAIL ram_write: addr %0d data %h expected addr %0d data %h",
                                 RamAddr, acc, w.addr, w.data);
                    end
                end
            end
        end
    end

    task automatic start_prog();
        Reset = 1'b0;
        Enter = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) mem[i] = 8'd0;
        ld_q.delete();
        wr_q.delete();
        chk++;
        if (StateOut !== 3'd0 || PcOut !== 5'd0 || RamAddr !== 5'd0 || Asel !== 2'b00 ||
            {RamWe, Aload, Sub, Halt} !== 4'b0000) begin
            err++;
            $display("FAIL reset_state: state %0d pc %0d addr %0d asel %b we/ld/sub/halt %b expected 0s",
                     StateOut, PcOut, RamAddr, Asel, {RamWe, Aload, Sub, Halt});
        end
    endtask

    task automatic release_rst();
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    task automatic wait_halt(input int max);
        for (int i = 0; i < max && Halt !== 1'b1; i++) @(negedge Clock);
        chk++;
        if (Halt !== 1'b1) begin
            err++;
            $display("FAIL halt_timeout: Halt %b expected 1 within %0d cycles", Halt, max);
        end
    endtask

    task automatic check_drained(input string name);
        chk++;
        if (ld_q.size() != 0 || wr_q.size() != 0) begin
            err++;
            $display("FAIL %s_drained: %0d loads %0d writes pending expected 0", name, ld_q.size(), wr_q.size());
        end
    endtask

    task automatic load_prog1();
        mem[0]  = {3'b000, 5'd20};
        mem[1]  = {3'b010, 5'd21};
        mem[2]  = {3'b001, 5'd22};
        mem[3]  = I_HALT;
        mem[20] = 8'd5;
        mem[21] = 8'd7;
    endtask

    task automatic test_reset();
        start_prog();
        repeat (3) @(negedge Clock);
        chk++;
        if (StateOut !== 3'd0 || PcOut !== 5'd0) begin
            err++;
            $display("FAIL reset_hold: state %0d pc %0d expected 0 0", StateOut, PcOut);
        end
    endtask

    task automatic test_load_add_store();
        start_prog();
        load_prog1();
        ld_q.push_back(ld_t'{2'b10, 1'b0, 8'd5});
        ld_q.push_back(ld_t'{2'b00, 1'b0, 8'd12});
        wr_q.push_back(wr_t'{5'd22, 8'd12});
        release_rst();
        repeat (13) @(negedge Clock);
        chk++;
        if (Halt !== 1'b0) begin
            err++;
            $display("FAIL early_halt: Halt %b after 13 cycles expected 0", Halt);
        end
        @(negedge Clock);
        chk++;
        if (Halt !== 1'b1 || PcOut !== 5'd4 || StateOut !== 3'd5 || mem[22] !== 8'd12) begin
            err++;
            $display("FAIL prog1_end: halt %b pc %0d state %0d m22 %h expected 1 4 5 0c",
                     Halt, PcOut, StateOut, mem[22]);
        end
        repeat (4) @(negedge Clock);
        chk++;
        if (Halt !== 1'b1 || PcOut !== 5'd4) begin
            err++;
            $display("FAIL halt_sticky: halt %b pc %0d expected 1 4", Halt, PcOut);
        end
        check_drained("prog1");
    endtask

    task automatic test_sub_jpos(input logic [7:0] m, input logic taken);
        logic [7:0] r;
        r = 8'd3 - m;
        start_prog();
        mem[0]  = {3'b000, 5'd20};
        mem[1]  = {3'b011, 5'd21};
        mem[2]  = {3'b110, 5'd10};
        mem[3]  = I_HALT;
        mem[10] = I_HALT;
        mem[20] = 8'd3;
        mem[21] = m;
        ld_q.push_back(ld_t'{2'b10, 1'b0, 8'd3});
        ld_q.push_back(ld_t'{2'b00, 1'b1, r});
        release_rst();
        repeat (11) @(negedge Clock);
        chk++;
        if (StateOut !== 3'd0 || PcOut !== (taken ? 5'd10 : 5'd3) || Apos !== taken) begin
            err++;
            $display("FAIL jpos_pc: state %0d pc %0d apos %b expected 0 %0d %b",
                     StateOut, PcOut, Apos, taken ? 10 : 3, taken);
        end
        wait_halt(10);
        chk++;
        if (PcOut !== (taken ? 5'd11 : 5'd4) || acc !== r) begin
            err++;
            $display("FAIL sub_end: pc %0d acc %h expected %0d %h", PcOut, acc, taken ? 11 : 4, r);
        end
        check_drained("sub_jpos");
    endtask

    task automatic test_jz_wrap(input logic [7:0] v);
        start_prog();
        mem[0]  = {3'b101, 5'd30};
        mem[1]  = I_HALT;
        mem[30] = {3'b000, 5'd20};
        mem[31] = {3'b101, 5'd0};
        mem[20] = v;
        ld_q.push_back(ld_t'{2'b10, 1'b0, v});
        release_rst();
        repeat (3) @(negedge Clock);
        chk++;
        if (PcOut !== 5'd30 || StateOut !== 3'd0) begin
            err++;
            $display("FAIL jz_taken: pc %0d state %0d expected 30 0", PcOut, StateOut);
        end
        repeat (7) @(negedge Clock);
        chk++;
        if (PcOut !== 5'd0 || StateOut !== 3'd0) begin
            err++;
            $display("FAIL pc_wrap: pc %0d state %0d expected 0 0", PcOut, StateOut);
        end
        if (v == 8'd0) begin
            repeat (3) @(negedge Clock);
            chk++;
            if (PcOut !== 5'd30) begin
                err++;
                $display("FAIL jz_again: pc %0d expected 30", PcOut);
            end
        end else begin
            wait_halt(10);
            chk++;
            if (PcOut !== 5'd2) begin
                err++;
                $display("FAIL jz_not_taken: pc %0d expected 2", PcOut);
            end
        end
        check_drained("jz");
    endtask

    task automatic test_input();
        int cnt0;
        start_prog();
        mem[0]  = {3'b100, 5'd0};
        mem[1]  = I_HALT;
        in_data = 8'h2A;
        ld_q.push_back(ld_t'{2'b01, 1'b0, 8'h2A});
        cnt0 = aload_cnt;
        release_rst();
        repeat (2) @(posedge Clock);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            chk++;
            if (StateOut !== 3'd2 || Aload !== 1'b0) begin
                err++;
                $display("FAIL input_wait: state %0d aload %b expected 2 0", StateOut, Aload);
            end
            @(posedge Clock);
        end
        #1 Enter = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clock);
            #1;
            chk++;
            if (StateOut !== 3'd4) begin
                err++;
                $display("FAIL inrel_hold: state %0d expected 4", StateOut);
            end
        end
        Enter = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        chk++;
        if (StateOut !== 3'd0 || PcOut !== 5'd1) begin
            err++;
            $display("FAIL input_release: state %0d pc %0d expected 0 1", StateOut, PcOut);
        end
        wait_halt(10);
        chk++;
        if (aload_cnt - cnt0 != 1 || acc !== 8'h2A) begin
            err++;
            $display("FAIL input_once: aloads %0d acc %h expected 1 2a", aload_cnt - cnt0, acc);
        end
        check_drained("input");
    endtask

    task automatic test_reset_mid_store();
        start_prog();
        mem[0]  = {3'b000, 5'd20};
        mem[1]  = {3'b001, 5'd22};
        mem[20] = 8'd9;
        ld_q.push_back(ld_t'{2'b10, 1'b0, 8'd9});
        release_rst();
        repeat (6) @(posedge Clock);
        #2;
        chk++;
        if (RamWe !== 1'b1 || StateOut !== 3'd2) begin
            err++;
            $display("FAIL store_exec: we %b state %0d expected 1 2", RamWe, StateOut);
        end
        Reset = 1'b0;
        #1;
        chk++;
        if (RamWe !== 1'b0 || Aload !== 1'b0 || StateOut !== 3'd0 || PcOut !== 5'd0) begin
            err++;
            $display("FAIL async_abort: we %b aload %b state %0d pc %0d expected 0 0 0 0",
                     RamWe, Aload, StateOut, PcOut);
        end
        @(posedge Clock);
        #1;
        chk++;
        if (mem[22] !== 8'd0) begin
            err++;
            $display("FAIL no_write: m22 %h expected 00", mem[22]);
        end
        check_drained("reset_mid");
    endtask

`ifdef CTRL_SINGLE_STEP_EN
    task automatic test_single_step();
        start_prog();
        load_prog1();
        Step = 1'b0;
        ld_q.push_back(ld_t'{2'b10, 1'b0, 8'd5});
        release_rst();
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            chk++;
            if (StateOut !== 3'd0 || PcOut !== 5'd0) begin
                err++;
                $display("FAIL step_hold: state %0d pc %0d expected 0 0", StateOut, PcOut);
            end
        end
        @(posedge Clock);
        #1 Step = 1'b1;
        @(posedge Clock);
        #1 Step = 1'b0;
        repeat (3) @(posedge Clock);
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            chk++;
            if (StateOut !== 3'd0 || PcOut !== 5'd1) begin
                err++;
                $display("FAIL step_one: state %0d pc %0d expected 0 1", StateOut, PcOut);
            end
        end
        check_drained("step");
        Step = 1'b1;
    endtask
`endif

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'd0;
        test_reset();
        test_load_add_store();
        test_sub_jpos(8'd5, 1'b0);
        test_sub_jpos(8'd1, 1'b1);
        test_jz_wrap(8'd0);
        test_jz_wrap(8'd4);
        test_input();
        test_reset_mid_store();
`ifdef CTRL_SINGLE_STEP_EN
        test_single_step();
`endif
        test_load_add_store();
        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end

endmodule
